// File: rtl/mult16appx_arb_pkg.sv
// Shared constants and round-robin pick function for mult16appx_arb.
// Holds operand/result widths, the requester ceiling and the grant search.
package mult16appx_arb_pkg;

   localparam int OP_W     = 16;
   localparam int RES_W    = 32;
   localparam int NREQ_MAX = 16;
   localparam int PTR_W    = 4;

   typedef struct packed {
      logic             found;
      logic [PTR_W-1:0] idx;
   } rr_pick_t;

   // First valid index at or above ptr, wrapping modulo n.
   // Scanned from the far end so the nearest offset wins.
   function automatic rr_pick_t rr_next(
      input logic [NREQ_MAX-1:0] valid,
      input logic [PTR_W-1:0]    ptr,
      input int                  n
   );
      rr_pick_t pick;
      int       c;
      pick = '0;
      for (int off = NREQ_MAX - 1; off >= 0; off--) begin
         if (off < n) begin
            c = int'(ptr) + off;
            if (c >= n) c = c - n;
            if (valid[c[PTR_W-1:0]]) begin
               pick.found = 1'b1;
               pick.idx   = c[PTR_W-1:0];
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mult16appx.sv
// Combinational approximate 16x16 multiplier: b is rounded to a power of two.
// Ports: a, b operands (16b); y approximate product (32b).
module mult16appx
   import mult16appx_arb_pkg::*;
(
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic [RES_W-1:0] y
);

   logic [4:0] msb;
   logic [4:0] msb_m1;
   logic       half;
   logic [4:0] k;

   // k = msb position, bumped by one when the next bit down is set,
   // i.e. b in [3*2^(k-2), 3*2^(k-1)) maps to shift k.
   always_comb begin
      msb = '0;
      for (int i = 0; i < OP_W; i++) begin
         if (b[i]) msb = 5'(i);
      end
      msb_m1 = msb - 5'd1;
      half   = (msb != 5'd0) ? b[msb_m1[3:0]] : 1'b0;
      k      = msb + {4'b0, half};
      if (b == '0) y = '0;
      else         y = {{(RES_W-OP_W){1'b0}}, a} << k;
   end

endmodule

// File: rtl/mult16appx_arb.sv
// Round-robin arbiter sharing one mult16appx among NREQ requesters.
// Ports: clk, rst (async high); req_valid/req_ready/req_a/req_b per
// requester; rsp_valid/rsp_ready/rsp_y/rsp_id response port.
// MULT16APPX_ARB_PIPE_EN adds an operand stage (latency 2 instead of 1).
module mult16appx_arb
   import mult16appx_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*OP_W-1:0] req_a,
   input  logic [NREQ*OP_W-1:0] req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [RES_W-1:0]     rsp_y,
   output logic [ID_W-1:0]      rsp_id
);

   logic [NREQ_MAX-1:0] vpad;
   rr_pick_t            pick;
   logic                adv;
   logic                gnt;
   logic [PTR_W-1:0]    rr_ptr;
   logic [OP_W-1:0]     ga;
   logic [OP_W-1:0]     gb;
   logic [OP_W-1:0]     ma;
   logic [OP_W-1:0]     mb;
   logic [RES_W-1:0]    my;
   logic                rv;
   logic [RES_W-1:0]    ry;
   logic [ID_W-1:0]     rid;

   // The result register is always the last stage.
   assign adv = !rv || rsp_ready;

   always_comb begin
      vpad            = '0;
      vpad[NREQ-1:0]  = req_valid;
      pick            = rr_next(vpad, rr_ptr, NREQ);
      gnt             = adv && !rst && pick.found;
      req_ready       = '0;
      ga              = '0;
      gb              = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick.idx == PTR_W'(i)) begin
            ga           = req_a[i*OP_W +: OP_W];
            gb           = req_b[i*OP_W +: OP_W];
            req_ready[i] = gnt;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (gnt) begin
         if (pick.idx == PTR_W'(NREQ - 1)) rr_ptr <= '0;
         else                              rr_ptr <= pick.idx + 1'b1;
      end
   end

`ifdef MULT16APPX_ARB_PIPE_EN
   logic             ov;
   logic [OP_W-1:0]  oa;
   logic [OP_W-1:0]  ob;
   logic [ID_W-1:0]  oid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ov  <= 1'b0;
         oa  <= '0;
         ob  <= '0;
         oid <= '0;
         rv  <= 1'b0;
         ry  <= '0;
         rid <= '0;
      end else if (adv) begin
         ov <= gnt;
         if (gnt) begin
            oa  <= ga;
            ob  <= gb;
            oid <= pick.idx[ID_W-1:0];
         end
         rv <= ov;
         if (ov) begin
            ry  <= my;
            rid <= oid;
         end
      end
   end

   assign ma = oa;
   assign mb = ob;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rv  <= 1'b0;
         ry  <= '0;
         rid <= '0;
      end else if (adv) begin
         rv <= gnt;
         if (gnt) begin
            ry  <= my;
            rid <= pick.idx[ID_W-1:0];
         end
      end
   end

   assign ma = ga;
   assign mb = gb;
`endif

   mult16appx u_mul (
      .a (ma),
      .b (mb),
      .y (my)
   );

   assign rsp_valid = rv;
   assign rsp_y     = ry;
   assign rsp_id    = rid;

endmodule

// File: doc/mult16appx_arb.md
# mult16appx_arb

Round-robin arbiter and result sequencer that shares one `mult16appx` approximate multiplier among `NREQ` requesters. Each requester presents a 16x16 operand pair with a valid/ready handshake. The block grants one requester per cycle, drives the shared multiplier, and returns the 32-bit result with the requester's id through a single valid/ready response port. It sits between the functional-unit issue logic and the shared multiplier in the FunctionalUnits datapath.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(NREQ)`: width of the response id.

- `clk`: input, 1 bit. Single clock; all state updates on rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `req_valid`: input, `NREQ` bits. Per-requester operand valid.
- `req_ready`: output, `NREQ` bits. Per-requester grant; one-hot or zero.
- `req_a`: input, `NREQ*16` bits. Operand a; requester i occupies bits [16i+15:16i].
- `req_b`: input, `NREQ*16` bits. Operand b; same packing as `req_a`.
- `rsp_valid`: output, 1 bit. Result valid.
- `rsp_ready`: input, 1 bit. Consumer accepts the result.
- `rsp_y`: output, 32 bits. Approximate product.
- `rsp_id`: output, `ID_W` bits. Index of the requester that produced this result.

## Operation
- Transfer rules:
  - A request transfers when `req_valid[i] && req_ready[i]`.
  - A response transfers when `rsp_valid && rsp_ready`.
  - A requester holds valid and operands stable until it is granted.
  - `req_ready` may depend combinationally on `req_valid`.
- Advance condition: `adv = !last_stage_valid || rsp_ready`.
  - Grants are issued only when `adv` is 1.
  - When `adv` is 0, all of `req_ready` is 0 and every pipeline register holds.
- Round-robin arbitration:
  - A pointer `rr_ptr` resets to 0.
  - The grant goes to the first `req_valid[i]` found searching from `rr_ptr` upward, wrapping modulo `NREQ`.
  - After a grant to i, `rr_ptr` becomes `(i+1) mod NREQ`.
  - `rr_ptr` is unchanged in any cycle without a grant.
- Multiplier function, k selected from b:
  - b=0: y=0.
  - b=1: y=a.
  - b=2: y=a<<1.
  - For k=2..15, b in [3·2^(k-2), 3·2^(k-1)): y=a<<k.
  - b≥49152: y=a<<16.
  - a is zero-extended to 32 bits; the result never overflows.
- Simultaneous response drain and new grant in the same cycle is allowed, giving a sustained throughput of one result per cycle.
- A requester that drops valid without being granted loses nothing; no state is kept per requester.

## Timing
- Reset values: `rsp_valid`=0, `rsp_y`=0, `rsp_id`=0, `rr_ptr`=0, all internal stage-valid bits 0. `req_ready` is 0 while `rst` is high.
- Default build: grant in cycle N. Operands pass through the multiplier combinationally and are captured into the response register at the end of cycle N. `rsp_valid` is high in cycle N+1, so latency is 1.
- `rsp_valid`, `rsp_y` and `rsp_id` stay stable while `rsp_valid && !rsp_ready`.
- Reset asserted mid-operation: in-flight results are discarded with no response emitted, and `rr_ptr` returns to 0.

## Configuration
- `MULT16APPX_ARB_PIPE_EN`:
  - Defined: an operand register stage is inserted before the multiplier, giving two stages (operand, result). Latency is 2.
  - Defined: both stages stall together on `!adv`, and up to 2 results can be in flight. Throughput stays at 1 per cycle.
  - Undefined: a single result register and latency 1, as described under Timing.

## Structure
- Package `mult16appx_arb_pkg` holds:
  - `OP_W`=16 and `RES_W`=32.
  - `NREQ_MAX`=16.
  - A function computing the next round-robin grant index.
- One sub-module: the existing combinational `mult16appx (a, b, y)`, instantiated once. The arbiter, pipeline registers and pointer live in `mult16appx_arb`.

## Test plan
- Single requester: requester 2 sends a=100, b=5, with `rsp_ready`=1. Expect `rsp_y`=400 and `rsp_id`=2 after the configured latency.
- Operand edges, requester 0:
  - a=3, b=7 gives 24.
  - a=1, b=49152 gives 65536.
  - a=0xFFFF, b=0xFFFF gives 0xFFFF0000.
  - a=9, b=0 gives 0.
- Fairness: all 4 requesters hold valid continuously with `rsp_ready`=1. Expect grant and `rsp_id` order 0,1,2,3,0,1 and one result per cycle.
- Backpressure: hold `rsp_ready`=0 for 3 cycles while results are pending. Expect `rsp_y` and `rsp_id` stable, `req_ready`=0 throughout, and no result lost or duplicated after release.
- Pointer skip: only requesters 1 and 3 valid, starting from `rr_ptr`=0. Expect grant order 1,3,1,3.
- Reset mid-flight: assert `rst` one cycle after a grant. Expect `rsp_valid`=0 immediately and no stale response after deassertion. The next grant goes to the lowest valid index.
